// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one pipelined multiplier between two requesters.
// Accepted operand pairs are round-robin arbitrated into a single issue register
// and tagged with the requester index in the MSB of the ctl field. Products
// coming back are steered by that tag into per-requester first-word-fall-through
// FIFOs. Issue is credit-limited, so the FIFOs always have room for every product
// still in flight. That is why o_mul_rdy can be tied high, and why one slow
// consumer can never block the other requester.
module mult_share_arb #(
    parameter int DAT_BITS = 381,
    parameter int CTL_BITS = 8,
    parameter int CREDITS  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // requester 0
    input  logic [2*DAT_BITS-1:0]   i_req0_dat,
    input  logic [CTL_BITS-1:0]     i_req0_ctl,
    input  logic                    i_req0_val,
    output logic                    o_req0_rdy,
    // requester 1
    input  logic [2*DAT_BITS-1:0]   i_req1_dat,
    input  logic [CTL_BITS-1:0]     i_req1_ctl,
    input  logic                    i_req1_val,
    output logic                    o_req1_rdy,
    // multiplier request side
    output logic [2*DAT_BITS-1:0]   o_mul_dat,
    output logic [CTL_BITS:0]       o_mul_ctl,
    output logic                    o_mul_val,
    input  logic                    i_mul_rdy,
    // multiplier product side
    input  logic [2*DAT_BITS-1:0]   i_mul_dat,
    input  logic [CTL_BITS:0]       i_mul_ctl,
    input  logic                    i_mul_val,
    output logic                    o_mul_rdy,
    // response 0
    output logic [2*DAT_BITS-1:0]   o_rsp0_dat,
    output logic [CTL_BITS-1:0]     o_rsp0_ctl,
    output logic                    o_rsp0_val,
    input  logic                    i_rsp0_rdy,
    // response 1
    output logic [2*DAT_BITS-1:0]   o_rsp1_dat,
    output logic [CTL_BITS-1:0]     o_rsp1_ctl,
    output logic                    o_rsp1_val,
    input  logic                    i_rsp1_rdy,
    // sticky protocol error
    output logic                    o_err
);

    localparam int NREQ     = 2;
    localparam int PRD_BITS = 2 * DAT_BITS;
    localparam int AW       = $clog2(CREDITS);
    localparam int CW       = $clog2(CREDITS) + 1;
    localparam int ENT_BITS = PRD_BITS + CTL_BITS;

    // Per-requester views of the flat ports, so the datapath can be generated
    logic                req_val  [NREQ];
    logic [PRD_BITS-1:0] req_dat  [NREQ];
    logic [CTL_BITS-1:0] req_ctl  [NREQ];
    logic                rsp_rdy  [NREQ];

    assign req_val[0] = i_req0_val;
    assign req_val[1] = i_req1_val;
    assign req_dat[0] = i_req0_dat;
    assign req_dat[1] = i_req1_dat;
    assign req_ctl[0] = i_req0_ctl;
    assign req_ctl[1] = i_req1_ctl;
    assign rsp_rdy[0] = i_rsp0_rdy;
    assign rsp_rdy[1] = i_rsp1_rdy;

    // Signals produced by the per-requester blocks
    logic                credit_avail [NREQ];
    logic                rsp_val      [NREQ];
    logic [ENT_BITS-1:0] rsp_word     [NREQ];
    logic                req_err      [NREQ];

    // Arbitration and issue register state
    logic                load_en;
    logic [NREQ-1:0]     elig;
    logic [NREQ-1:0]     grant;
    logic                mul_val_q, mul_val_d;
    logic [PRD_BITS-1:0] mul_dat_q, mul_dat_d;
    logic [CTL_BITS:0]   mul_ctl_q, mul_ctl_d;
    logic                rr_last_q, rr_last_d;
    logic                err_q, err_d;

    // Round-robin grant into the issue register; the register only reloads
    // when it is empty or the multiplier is taking its current content.
    always_comb begin
        load_en = ~mul_val_q | i_mul_rdy;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_val[i] & credit_avail[i];
        end

        grant = '0;
        if (load_en) begin
            if (elig[0] && elig[1]) begin
                grant = rr_last_q ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end

        mul_val_d = mul_val_q;
        mul_dat_d = mul_dat_q;
        mul_ctl_d = mul_ctl_q;
        rr_last_d = rr_last_q;
        if (load_en) begin
            mul_val_d = |grant;
            if (grant[0]) begin
                mul_dat_d = req_dat[0];
                mul_ctl_d = {1'b0, req_ctl[0]};
                rr_last_d = 1'b0;
            end else if (grant[1]) begin
                mul_dat_d = req_dat[1];
                mul_ctl_d = {1'b1, req_ctl[1]};
                rr_last_d = 1'b1;
            end
        end
    end

    // Sticky error: any credit or FIFO accounting violation from either side
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NREQ; i++) begin
            err_d = err_d | req_err[i];
        end
    end

    // Issue register, arbitration history and error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mul_val_q <= 1'b0;
            mul_dat_q <= '0;
            mul_ctl_q <= '0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            mul_val_q <= mul_val_d;
            mul_dat_q <= mul_dat_d;
            mul_ctl_q <= mul_ctl_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    // Credit counter and response FIFO, one per requester
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [CW-1:0]       credit_q, credit_d;
        logic [AW:0]         wr_ptr_q, wr_ptr_d;
        logic [AW:0]         rd_ptr_q, rd_ptr_d;
        logic [ENT_BITS-1:0] fifo_mem [CREDITS];
        logic                push, pop, wr_en;
        logic                empty, full;
        logic                credit_ovf, push_drop, push_unexp;

        // FIFO pointer and credit bookkeeping. A pop on a full FIFO frees its
        // slot before the same-cycle push is considered.
        always_comb begin
            push       = i_mul_val & (i_mul_ctl[CTL_BITS] == 1'(gi));
            empty      = (wr_ptr_q == rd_ptr_q);
            full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            pop        = ~empty & rsp_rdy[gi];
            wr_en      = push & (~full | pop);
            push_drop  = push & ~wr_en;
            // With every credit home nothing can be in flight for us.
            push_unexp = push & (credit_q == CW'(CREDITS));

            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end

            credit_d   = credit_q;
            credit_ovf = 1'b0;
            if (grant[gi] && !pop) begin
                credit_d = credit_q - CW'(1);
            end else if (!grant[gi] && pop) begin
                if (credit_q == CW'(CREDITS)) begin
                    credit_ovf = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
        end

        // Pointer and credit registers
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                credit_q <= CW'(CREDITS);
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                credit_q <= credit_d;
            end
        end

        // Response storage; contents need no reset since the pointers gate it
        always_ff @(posedge i_clk) begin
            if (wr_en) begin
                fifo_mem[wr_ptr_q[AW-1:0]] <= {i_mul_dat, i_mul_ctl[CTL_BITS-1:0]};
            end
        end

        assign credit_avail[gi] = (credit_q != '0);
        assign rsp_val[gi]      = ~empty;
        assign rsp_word[gi]     = fifo_mem[rd_ptr_q[AW-1:0]];
        assign req_err[gi]      = credit_ovf | push_drop | push_unexp;
    end

    assign o_req0_rdy = grant[0];
    assign o_req1_rdy = grant[1];

    assign o_mul_dat  = mul_dat_q;
    assign o_mul_ctl  = mul_ctl_q;
    assign o_mul_val  = mul_val_q;
    assign o_mul_rdy  = 1'b1;

    assign o_rsp0_dat = rsp_word[0][CTL_BITS +: PRD_BITS];
    assign o_rsp0_ctl = rsp_word[0][CTL_BITS-1:0];
    assign o_rsp0_val = rsp_val[0];
    assign o_rsp1_dat = rsp_word[1][CTL_BITS +: PRD_BITS];
    assign o_rsp1_ctl = rsp_word[1][CTL_BITS-1:0];
    assign o_rsp1_val = rsp_val[1];

    assign o_err      = err_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed and randomized checks of mult_share_arb against a
// transaction-level model: outstanding-request counts per requester, expected
// product queues (a*b computed here), and an in-order multiplier model.
`timescale 1ns/1ps
module tb_mult_share_arb;
    localparam int DAT  = 381;
    localparam int CTL  = 8;
    localparam int CRED = 8;
    localparam int PW   = 2 * DAT;
    localparam int QN   = 1024;

    typedef logic [PW-1:0] prd_t;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [PW-1:0]  i_req0_dat, i_req1_dat;
    logic [CTL-1:0] i_req0_ctl, i_req1_ctl;
    logic           i_req0_val, i_req1_val;
    logic           o_req0_rdy, o_req1_rdy;
    logic [PW-1:0]  o_mul_dat;
    logic [CTL:0]   o_mul_ctl;
    logic           o_mul_val;
    logic           i_mul_rdy;
    logic [PW-1:0]  i_mul_dat;
    logic [CTL:0]   i_mul_ctl;
    logic           i_mul_val;
    logic           o_mul_rdy;
    logic [PW-1:0]  o_rsp0_dat, o_rsp1_dat;
    logic [CTL-1:0] o_rsp0_ctl, o_rsp1_ctl;
    logic           o_rsp0_val, o_rsp1_val;
    logic           i_rsp0_rdy, i_rsp1_rdy;
    logic           o_err;

    always #5 i_clk = ~i_clk;

    mult_share_arb #(.DAT_BITS(DAT), .CTL_BITS(CTL), .CREDITS(CRED)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_dat(i_req0_dat), .i_req0_ctl(i_req0_ctl), .i_req0_val(i_req0_val), .o_req0_rdy(o_req0_rdy),
        .i_req1_dat(i_req1_dat), .i_req1_ctl(i_req1_ctl), .i_req1_val(i_req1_val), .o_req1_rdy(o_req1_rdy),
        .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
        .i_mul_dat(i_mul_dat), .i_mul_ctl(i_mul_ctl), .i_mul_val(i_mul_val), .o_mul_rdy(o_mul_rdy),
        .o_rsp0_dat(o_rsp0_dat), .o_rsp0_ctl(o_rsp0_ctl), .o_rsp0_val(o_rsp0_val), .i_rsp0_rdy(i_rsp0_rdy),
        .o_rsp1_dat(o_rsp1_dat), .o_rsp1_ctl(o_rsp1_ctl), .o_rsp1_val(o_rsp1_val), .i_rsp1_rdy(i_rsp1_rdy),
        .o_err(o_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input prd_t obs, input prd_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // stimulus sources
    logic [DAT-1:0] src_a [2][QN];
    logic [DAT-1:0] src_b [2][QN];
    logic [CTL-1:0] src_c [2][QN];
    int src_wr [2];
    int src_rd [2];
    // expected responses, in acceptance order
    prd_t           exp_p [2][QN];
    logic [CTL-1:0] exp_c [2][QN];
    int exp_wr [2];
    int exp_rd [2];
    // multiplier model pipeline
    prd_t         mq_p   [QN];
    logic [CTL:0] mq_c   [QN];
    int           mq_due [QN];
    int mq_wr, mq_rd, last_due;
    // abstract arbiter state
    int   outst   [2];
    int   fcnt    [2];
    int   acc_cnt [2];
    int   rsp_cnt [2];
    bit   iss_full;
    prd_t iss_dat;
    logic [CTL:0] iss_ctl;
    int   rr_last;
    bit   exp_err;
    int   seq [64];
    int   seq_n;
    prd_t rsp_log [8];
    int   cyc = 0;
    // stimulus knobs
    int p_val [2];
    int p_rsp [2];
    int p_mul, lat_min, lat_max;
    bit mul_en, inj_en;

    function automatic logic [DAT-1:0] rand_op();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom();
        return t[DAT-1:0];
    endfunction

    task automatic add_src(input int r, input logic [DAT-1:0] a, input logic [DAT-1:0] b, input logic [CTL-1:0] c);
        src_a[r][src_wr[r] % QN] = a;
        src_b[r][src_wr[r] % QN] = b;
        src_c[r][src_wr[r] % QN] = c;
        src_wr[r]++;
    endtask

    task automatic add_rand(input int r, input int n);
        for (int i = 0; i < n; i++) add_src(r, rand_op(), rand_op(), CTL'($urandom()));
    endtask

    task automatic knobs_default();
        p_val[0] = 100; p_val[1] = 100;
        p_rsp[0] = 100; p_rsp[1] = 100;
        p_mul = 100; lat_min = 4; lat_max = 4;
        mul_en = 1'b1; inj_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            src_rd[r] = src_wr[r];
            exp_rd[r] = exp_wr[r];
            outst[r] = 0; fcnt[r] = 0; acc_cnt[r] = 0; rsp_cnt[r] = 0;
        end
        mq_rd = mq_wr; last_due = cyc;
        iss_full = 1'b0; iss_dat = '0; iss_ctl = '0;
        rr_last = 1; exp_err = 1'b0; seq_n = 0;
    endtask

    // Reset with a stray tag-1 product on the bus; it must be ignored.
    task automatic do_reset();
        i_rst = 1'b1;
        i_req0_val = 1'b0; i_req1_val = 1'b0;
        i_rsp0_rdy = 1'b0; i_rsp1_rdy = 1'b0; i_mul_rdy = 1'b0;
        i_mul_val = 1'b1; i_mul_ctl = {1'b1, 8'h5A}; i_mul_dat = PW'(42);
        @(posedge i_clk); @(posedge i_clk); #1;
        check("rst_mul_val", o_mul_val, 0);
        check("rst_mul_dat", o_mul_dat, 0);
        check("rst_mul_ctl", o_mul_ctl, 0);
        check("rst_rsp0_val", o_rsp0_val, 0);
        check("rst_rsp1_val", o_rsp1_val, 0);
        check("rst_err", o_err, 0);
        i_rst = 1'b0; i_mul_val = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive at posedge+1, check and update model at negedge.
    task automatic step();
        logic v [2]; prd_t d [2]; logic [CTL-1:0] c [2]; logic rr [2];
        logic rv [2]; prd_t rdat [2]; logic [CTL-1:0] rctl [2]; logic ar [2];
        bit push_v; logic [CTL:0] push_c; bit ld, err_now; bit el [2];
        int win, lat, due, t, k;
        for (int r = 0; r < 2; r++) begin
            k = src_rd[r] % QN;
            if (src_rd[r] != src_wr[r] && $urandom_range(99) < p_val[r]) begin
                v[r] = 1'b1; d[r] = {src_b[r][k], src_a[r][k]}; c[r] = src_c[r][k];
            end else begin
                v[r] = 1'b0; d[r] = PW'({$urandom(), $urandom()}); c[r] = CTL'($urandom());
            end
            rr[r] = ($urandom_range(99) < p_rsp[r]);
        end
        i_req0_val = v[0]; i_req0_dat = d[0]; i_req0_ctl = c[0];
        i_req1_val = v[1]; i_req1_dat = d[1]; i_req1_ctl = c[1];
        i_rsp0_rdy = rr[0]; i_rsp1_rdy = rr[1];
        i_mul_rdy = ($urandom_range(99) < p_mul);
        push_v = 1'b0; push_c = '0;
        if (inj_en) begin
            i_mul_val = 1'b1; i_mul_ctl = {1'b0, 8'hA5}; i_mul_dat = PW'(32'h1234);
            push_v = 1'b1; push_c = i_mul_ctl;
        end else if (mul_en && mq_rd != mq_wr && mq_due[mq_rd % QN] <= cyc) begin
            i_mul_val = 1'b1; i_mul_dat = mq_p[mq_rd % QN]; i_mul_ctl = mq_c[mq_rd % QN];
            push_v = 1'b1; push_c = i_mul_ctl; mq_rd++;
        end else begin
            i_mul_val = 1'b0; i_mul_dat = PW'($urandom()); i_mul_ctl = (CTL+1)'($urandom());
        end

        @(negedge i_clk);
        rv[0] = o_rsp0_val; rdat[0] = o_rsp0_dat; rctl[0] = o_rsp0_ctl;
        rv[1] = o_rsp1_val; rdat[1] = o_rsp1_dat; rctl[1] = o_rsp1_ctl;
        ar[0] = o_req0_rdy & v[0]; ar[1] = o_req1_rdy & v[1];

        // expected arbitration from the credit/round-robin rules
        ld = !iss_full || i_mul_rdy;
        for (int r = 0; r < 2; r++) el[r] = v[r] && (outst[r] < CRED);
        win = -1;
        if (ld) begin
            if (el[0] && el[1]) win = (rr_last == 1) ? 0 : 1;
            else if (el[0]) win = 0;
            else if (el[1]) win = 1;
        end
        check("req0_rdy", o_req0_rdy, win == 0);
        check("req1_rdy", o_req1_rdy, win == 1);
        check("mul_val", o_mul_val, iss_full);
        if (iss_full) begin
            check("mul_dat", o_mul_dat, iss_dat);
            check("mul_ctl", o_mul_ctl, iss_ctl);
        end
        check("mul_rdy_tie", o_mul_rdy, 1);
        check("err", o_err, exp_err);

        err_now = push_v && outst[push_c[CTL]] == 0;
        for (int r = 0; r < 2; r++) begin
            if (rv[r] && rr[r] && outst[r] == 0) err_now = 1'b1;
            check(r == 0 ? "rsp0_val" : "rsp1_val", rv[r], fcnt[r] > 0);
            if (rv[r] && exp_rd[r] != exp_wr[r]) begin
                check(r == 0 ? "rsp0_dat" : "rsp1_dat", rdat[r], exp_p[r][exp_rd[r] % QN]);
                check(r == 0 ? "rsp0_ctl" : "rsp1_ctl", rctl[r], exp_c[r][exp_rd[r] % QN]);
            end
            if (rv[r] && rr[r]) begin
                if (exp_rd[r] != exp_wr[r]) exp_rd[r]++;
                if (outst[r] > 0) outst[r]--;
                if (fcnt[r] > 0) fcnt[r]--;
                if (r == 0 && rsp_cnt[0] < 8) rsp_log[rsp_cnt[0]] = rdat[0];
                rsp_cnt[r]++;
            end
        end

        // multiplier model takes the issued pair
        if (o_mul_val && i_mul_rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_p[mq_wr % QN] = prd_t'(o_mul_dat[DAT-1:0]) * prd_t'(o_mul_dat[PW-1:DAT]);
            mq_c[mq_wr % QN] = o_mul_ctl;
            mq_due[mq_wr % QN] = due;
            mq_wr++;
        end

        for (int r = 0; r < 2; r++) begin
            if (ar[r]) begin
                k = src_rd[r] % QN;
                exp_p[r][exp_wr[r] % QN] = prd_t'(src_a[r][k]) * prd_t'(src_b[r][k]);
                exp_c[r][exp_wr[r] % QN] = src_c[r][k];
                exp_wr[r]++; src_rd[r]++; outst[r]++; acc_cnt[r]++;
                if (seq_n < 64) begin seq[seq_n] = r; seq_n++; end
            end
        end
        if (ld) begin
            if (ar[0]) begin iss_full = 1'b1; iss_dat = d[0]; iss_ctl = {1'b0, c[0]}; rr_last = 0; end
            else if (ar[1]) begin iss_full = 1'b1; iss_dat = d[1]; iss_ctl = {1'b1, c[1]}; rr_last = 1; end
            else iss_full = 1'b0;
        end
        if (push_v) begin
            t = int'(push_c[CTL]);
            if (fcnt[t] < CRED) fcnt[t]++;
        end
        if (err_now) exp_err = 1'b1;

        @(posedge i_clk); #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int max, input string tag);
        bit busy;
        busy = 1'b1;
        for (int i = 0; i < max && busy; i++) begin
            step();
            busy = (src_rd[0] != src_wr[0]) || (src_rd[1] != src_wr[1]) || outst[0] > 0 || outst[1] > 0;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DAT-1:0] big;
        prd_t big_prod;
        int n0, alt, base, guard;
        for (int r = 0; r < 2; r++) begin src_wr[r] = 0; exp_wr[r] = 0; end
        mq_wr = 0;
        i_req0_dat = '0; i_req1_dat = '0; i_req0_ctl = '0; i_req1_ctl = '0;
        knobs_default();
        @(posedge i_clk); #1;
        do_reset();

        // single requester with known products
        big = '0; big[DAT-1] = 1'b1;
        big_prod = '0; big_prod[381] = 1'b1;
        add_src(0, DAT'(3), DAT'(5), 8'h11);
        add_src(0, DAT'(7), DAT'(11), 8'h22);
        add_src(0, big, DAT'(2), 8'h33);
        run_until_idle(60, "t1_idle");
        check("t1_acc0", acc_cnt[0], 3);
        check("t1_rsp0_cnt", rsp_cnt[0], 3);
        check("t1_rsp1_cnt", rsp_cnt[1], 0);
        check("t1_prod0", rsp_log[0], 15);
        check("t1_prod1", rsp_log[1], 77);
        check("t1_prod2", rsp_log[2], big_prod);
        $display("single requester: %0d responses", rsp_cnt[0]);

        // fairness with both requesters always valid
        do_reset();
        add_rand(0, 12); add_rand(1, 12);
        guard = 0;
        while (seq_n < 16 && guard < 40) begin step(); guard++; end
        check("fair_tmo", seq_n >= 16, 1);
        n0 = 0; alt = 0;
        for (int i = 0; i < 16; i++) begin
            if (seq[i] == 0) n0++;
            if (i > 0 && seq[i] != seq[i-1]) alt++;
        end
        check("fair_first", seq[0], 0);
        check("fair_split", n0, 8);
        check("fair_alternate", alt, 15);
        run_until_idle(100, "fair_idle");
        $display("fairness: %0d of first 16 to req0", n0);

        // credit exhaustion on requester 0
        do_reset();
        add_rand(0, 20); add_rand(1, 20);
        p_rsp[0] = 0;
        repeat (40) step();
        check("cx_acc0", acc_cnt[0], 8);
        check("cx_req1_flow", acc_cnt[1] > 8, 1);
        p_rsp[0] = 100; step(); p_rsp[0] = 0;
        repeat (20) step();
        check("cx_acc0_after_pop", acc_cnt[0], 9);
        p_rsp[0] = 100;
        run_until_idle(200, "cx_idle");
        $display("credit exhaustion: req0 accepts %0d", acc_cnt[0]);

        // multiplier backpressure
        do_reset();
        add_rand(0, 10); add_rand(1, 10);
        repeat (3) step();
        base = acc_cnt[0] + acc_cnt[1];
        p_mul = 0;
        repeat (5) step();
        check("bp_no_accept", acc_cnt[0] + acc_cnt[1], base);
        p_mul = 100;
        step();
        check("bp_resume", acc_cnt[0] + acc_cnt[1], base + 1);
        run_until_idle(100, "bp_idle");
        $display("backpressure: accepts held at %0d", base);

        // simultaneous grant and pop on requester 1 with 3 credits left
        do_reset();
        add_rand(1, 30);
        p_rsp[1] = 0;
        guard = 0;
        while (outst[1] < 5 && guard < 20) begin step(); guard++; end
        p_val[1] = 0;
        guard = 0;
        while (fcnt[1] < 5 && guard < 30) begin step(); guard++; end
        check("c3_setup", fcnt[1] == 5 && outst[1] == 5, 1);
        base = acc_cnt[1];
        p_val[1] = 100; p_rsp[1] = 100;
        step();
        check("c3_grant_with_pop", acc_cnt[1], base + 1);
        p_rsp[1] = 0;
        base = acc_cnt[1];
        repeat (15) step();
        check("c3_remaining_credit", acc_cnt[1] - base, 3);
        p_rsp[1] = 100;
        run_until_idle(200, "c3_idle");
        $display("credit3 corner: %0d responses on req1", rsp_cnt[1]);

        // randomized traffic with variable multiplier latency
        do_reset();
        lat_min = 1; lat_max = 7;
        add_rand(0, 250); add_rand(1, 250);
        for (int i = 0; i < 3000 && (src_rd[0] != src_wr[0] || src_rd[1] != src_wr[1]); i++) begin
            if (i % 50 == 0) begin
                p_val[0] = $urandom_range(100, 30); p_val[1] = $urandom_range(100, 30);
                p_rsp[0] = $urandom_range(100, 20); p_rsp[1] = $urandom_range(100, 20);
                p_mul = $urandom_range(100, 30);
            end
            step();
        end
        knobs_default();
        run_until_idle(400, "rand_idle");
        check("rand_all_returned", rsp_cnt[0] + rsp_cnt[1], 500);
        $display("random: %0d/%0d responses", rsp_cnt[0], rsp_cnt[1]);

        // reset in the middle of traffic
        add_rand(0, 10); add_rand(1, 10);
        repeat (6) step();
        do_reset();
        repeat (5) step();
        $display("mid-op reset: model cleared");

        // error injection: unexpected tag-0 product with all credits home
        p_rsp[0] = 0;
        inj_en = 1'b1; step(); inj_en = 1'b0;
        check("inj_err_rise", o_err, 1);
        repeat (5) step();
        check("inj_err_sticky", o_err, 1);
        do_reset();
        knobs_default();
        repeat (3) step();
        check("inj_err_cleared", o_err, 0);
        $display("error injection: sticky until reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
